rom_byte_streamer: RTL and testbench
====================================

Name: rom_byte_streamer

Overview:
Sequencer that sits directly upstream of the 4x8 registered ROM. It drives the ROM address and consumes the ROM data output. On a start pulse it walks addresses 0..DEPTH-1 and accounts for the ROM's one-cycle read latency. Each byte is presented on a valid/ready handshake to the downstream UART transmit path.

Parameters:
DEPTH, 10, number of ROM words streamed per run (1..2^ADDR_W)
ADDR_W, 4, ROM address width

Ports:
CLOCK  input  1  system clock, all logic on rising edge
RESET_N  input  1  asynchronous active-low reset
start  input  1  one-cycle request to stream the ROM; sampled only in IDLE
rom_addr  output  ADDR_W  address to ROM; registered
rom_data  input  8  ROM data_out; valid the cycle after rom_addr is stable for one edge
tx_data  output  8  byte to downstream; registered
tx_valid  output  1  tx_data holds a valid byte
tx_ready  input  1  downstream accepts the byte when tx_valid & tx_ready at a rising edge
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse after the last byte is accepted

Behaviour:
- Reset (RESET_N low, asynchronous): state=IDLE, rom_addr=0, tx_data=8'h00, tx_valid=0, busy=0, done=0. Reset takes effect immediately, including mid-stream. No partial run resumes after release.
- States: IDLE, FETCH, CAPTURE, SEND.
- IDLE: rom_addr=0, tx_valid=0. start=1 at an edge -> FETCH. start=0 -> stay.
- FETCH (1 cycle): rom_addr is stable; the ROM registers mem[rom_addr] at the closing edge -> CAPTURE.
- CAPTURE (1 cycle): at the closing edge, tx_data<=rom_data and tx_valid<=1 -> SEND.
- SEND: tx_valid=1 and tx_data held stable until handshake; no change while tx_ready=0.
- On handshake (tx_valid & tx_ready at an edge), tx_valid<=0, then:
  - if rom_addr==DEPTH-1: rom_addr<=0, done<=1 for exactly one cycle, next state IDLE.
  - otherwise: rom_addr<=rom_addr+1, next state FETCH.
- Latency: with start high at edge E0, FETCH occupies cycle E0..E1, CAPTURE occupies E1..E2, and tx_valid is high after E2.
- Throughput: with tx_ready held high, one byte every 3 cycles. Total run is 3*DEPTH cycles from start edge to the done pulse; done is high in the cycle after the last handshake.
- busy=1 from the start edge through the last handshake edge. busy=0 in the cycle done is high (state IDLE).
- start while busy is ignored, with no restart or queueing. start in the same cycle as done is accepted, because the state is IDLE.
- rom_addr never exceeds DEPTH-1; it has no wrap beyond DEPTH. Address arithmetic is ADDR_W bits unsigned.
- tx_ready while tx_valid=0 has no effect.
- DEPTH=1: single byte from address 0, then done.

Test Plan:
1. Hold RESET_N low, toggle start/tx_ready -> rom_addr=0, tx_valid=0, busy=0, done=0, tx_data=0.
2. Default ROM contents, DEPTH=10, pulse start, tx_ready=1 -> accepted bytes in order 5,10,10,10,10,10,10,10,10,10. tx_valid rises 2 cycles after the start edge and every 3 cycles after that. done pulses once, 30 cycles after the start edge.
3. Backpressure: tx_ready low for 7 cycles on byte 0 -> tx_valid stays 1, tx_data stays 5, rom_addr stays 0. Release -> stream resumes with 10 at address 1; no byte lost or duplicated.
4. Pulse start again at byte 4 of an active run -> ignored, with a single done and 10 bytes total. Pulse start in the done cycle -> new run starts at address 0.
5. Assert RESET_N low while in SEND on byte 6 -> tx_valid drops immediately and rom_addr=0. After release with no start, the block stays IDLE with no done.
6. DEPTH=1, pulse start -> exactly one byte of 5, done 3 cycles after the start edge, busy high for 3 cycles.

Source files
------------

// File: rtl/rom_byte_streamer.sv
// Walks a registered ROM from address 0 to DEPTH-1 and presents each byte on a
// valid/ready handshake. Each byte takes three cycles: address, ROM read, send.
module rom_byte_streamer #(
  parameter int DEPTH  = 10,
  parameter int ADDR_W = 4
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    CAPTURE = 2'd2,
    SEND    = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_reg,    state_next;
  logic [ADDR_W-1:0] rom_addr_reg, rom_addr_next;
  logic [7:0]        tx_data_reg,  tx_data_next;
  logic              tx_valid_reg, tx_valid_next;
  logic              done_reg,     done_next;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg    <= IDLE;
      rom_addr_reg <= '0;
      tx_data_reg  <= 8'h00;
      tx_valid_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rom_addr_reg <= rom_addr_next;
      tx_data_reg  <= tx_data_next;
      tx_valid_reg <= tx_valid_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    rom_addr_next = rom_addr_reg;
    tx_data_next  = tx_data_reg;
    tx_valid_next = tx_valid_reg;
    done_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        rom_addr_next = '0;
        tx_valid_next = 1'b0;
        if (start) begin
          state_next = FETCH;
        end
      end

      // The ROM samples rom_addr at the edge closing this state.
      FETCH: begin
        state_next = CAPTURE;
      end

      CAPTURE: begin
        tx_data_next  = rom_data;
        tx_valid_next = 1'b1;
        state_next    = SEND;
      end

      SEND: begin
        if (tx_valid_reg && tx_ready) begin
          tx_valid_next = 1'b0;
          if (rom_addr_reg == LAST_ADDR) begin
            rom_addr_next = '0;
            done_next     = 1'b1;
            state_next    = IDLE;
          end else begin
            rom_addr_next = rom_addr_reg + ADDR_W'(1);
            state_next    = FETCH;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign rom_addr = rom_addr_reg;
  assign tx_data  = tx_data_reg;
  assign tx_valid = tx_valid_reg;
  assign done     = done_reg;
  assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_rom_byte_streamer.sv
// Directed bench for rom_byte_streamer: a DEPTH=10 and a DEPTH=1 instance, each
// fed by a registered ROM model whose word 0 is 5 and all other words are 10.
module tb_rom_byte_streamer;

  logic       CLOCK;
  logic       RESET_N;

  logic       start0, tx_ready0;
  logic [3:0] rom_addr0;
  logic [7:0] rom_data0, tx_data0;
  logic       tx_valid0, busy0, done0;

  logic       start1, tx_ready1;
  logic [3:0] rom_addr1;
  logic [7:0] rom_data1, tx_data1;
  logic       tx_valid1, busy1, done1;

  logic [7:0] rom_mem [16];

  int pass_cnt  = 0;
  int total_cnt = 0;

  rom_byte_streamer #(.DEPTH(10), .ADDR_W(4)) dut0 (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .start(start0),
    .rom_addr(rom_addr0), .rom_data(rom_data0),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
    .busy(busy0), .done(done0)
  );

  rom_byte_streamer #(.DEPTH(1), .ADDR_W(4)) dut1 (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .start(start1),
    .rom_addr(rom_addr1), .rom_data(rom_data1),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
    .busy(busy1), .done(done1)
  );

  initial begin
    rom_mem[0] = 8'd5;
    for (int i = 1; i < 16; i++) rom_mem[i] = 8'd10;
  end

  always @(posedge CLOCK) begin
    rom_data0 <= rom_mem[rom_addr0];
    rom_data1 <= rom_mem[rom_addr1];
  end

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  function automatic logic [7:0] exp_byte(input int idx);
    return (idx == 0) ? 8'd5 : 8'd10;
  endfunction

  // Steps until done, checking every accepted byte; optionally pulses start
  // once while byte restart_addr is on offer.
  task automatic run_stream(input int max_cycles, input int restart_addr, output int bytes);
    bit pulsed = 0;
    bit seen = 0;
    bytes = 0;
    for (int c = 0; c < max_cycles && !seen; c++) begin
      start0 = 1'b0;
      if (!pulsed && restart_addr >= 0 && tx_valid0 && int'(rom_addr0) == restart_addr) begin
        start0 = 1'b1;
        pulsed = 1;
      end
      if (tx_valid0 && tx_ready0) begin
        $display("byte %0d addr %0d data %0d", bytes, rom_addr0, tx_data0);
        check_eq("hs_data", tx_data0, exp_byte(bytes));
        check_eq("hs_addr", rom_addr0, bytes);
        bytes++;
      end
      step();
      if (done0) seen = 1;
    end
    start0 = 1'b0;
    check_eq("done_seen", seen, 1);
  endtask

  initial begin
    int  nbytes;
    bit  found;

    RESET_N   = 1'b0;
    start0    = 1'b0;
    tx_ready0 = 1'b0;
    start1    = 1'b0;
    tx_ready1 = 1'b1;

    // 1: reset held, inputs toggling
    for (int i = 0; i < 4; i++) begin
      start0    = ~start0;
      tx_ready0 = ~tx_ready0;
      step();
      check_eq("rst_addr", rom_addr0, 0);
      check_eq("rst_valid", tx_valid0, 0);
      check_eq("rst_busy", busy0, 0);
      check_eq("rst_done", done0, 0);
      check_eq("rst_data", tx_data0, 0);
    end
    start0    = 1'b0;
    tx_ready0 = 1'b0;
    RESET_N   = 1'b1;
    step();
    check_eq("idle_busy", busy0, 0);

    // 2: full run with tx_ready high, exact cycle timing
    tx_ready0 = 1'b1;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    check_eq("t2_busy_e0", busy0, 1);
    check_eq("t2_valid_e0", tx_valid0, 0);
    for (int k = 0; k < 10; k++) begin
      step();
      check_eq("t2_valid_capture", tx_valid0, 0);
      step();
      check_eq("t2_valid_send", tx_valid0, 1);
      check_eq("t2_data", tx_data0, exp_byte(k));
      check_eq("t2_addr", rom_addr0, k);
      $display("byte %0d addr %0d data %0d", k, rom_addr0, tx_data0);
      step();
      check_eq("t2_valid_after_hs", tx_valid0, 0);
      check_eq("t2_done", done0, (k == 9) ? 1 : 0);
      check_eq("t2_busy", busy0, (k == 9) ? 0 : 1);
    end
    step();
    check_eq("t2_done_single", done0, 0);
    check_eq("t2_idle", busy0, 0);

    // 3: backpressure on byte 0
    tx_ready0 = 1'b0;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    step();
    step();
    check_eq("t3_valid", tx_valid0, 1);
    for (int i = 0; i < 7; i++) begin
      step();
      check_eq("t3_hold_valid", tx_valid0, 1);
      check_eq("t3_hold_data", tx_data0, 5);
      check_eq("t3_hold_addr", rom_addr0, 0);
    end
    tx_ready0 = 1'b1;
    run_stream(200, -1, nbytes);
    check_eq("t3_bytes", nbytes, 10);

    // 4: start mid-run ignored; start in done cycle accepted
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    run_stream(200, 4, nbytes);
    check_eq("t4_bytes", nbytes, 10);
    check_eq("t4_done_idle", busy0, 0);
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    check_eq("t4_restart_busy", busy0, 1);
    check_eq("t4_restart_addr", rom_addr0, 0);
    check_eq("t4_done_cleared", done0, 0);
    step();
    step();
    check_eq("t4_restart_valid", tx_valid0, 1);
    check_eq("t4_restart_data", tx_data0, 5);
    run_stream(200, -1, nbytes);
    check_eq("t4_second_bytes", nbytes, 10);
    step();
    check_eq("t4_done_once", done0, 0);

    // 5: reset while byte 6 is on offer
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (tx_valid0 && rom_addr0 == 4'd6) found = 1;
      else step();
    end
    check_eq("t5_reached_byte6", found, 1);
    tx_ready0 = 1'b0;
    #2;
    RESET_N = 1'b0;
    #1;
    check_eq("t5_valid_async", tx_valid0, 0);
    check_eq("t5_addr_async", rom_addr0, 0);
    check_eq("t5_busy_async", busy0, 0);
    step();
    step();
    RESET_N = 1'b1;
    tx_ready0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("t5_no_done", done0, 0);
      check_eq("t5_stay_idle", busy0, 0);
    end

    // 6: DEPTH=1 instance
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    check_eq("t6_busy_e0", busy1, 1);
    step();
    check_eq("t6_busy_e1", busy1, 1);
    check_eq("t6_valid_e1", tx_valid1, 0);
    step();
    check_eq("t6_busy_e2", busy1, 1);
    check_eq("t6_valid_e2", tx_valid1, 1);
    check_eq("t6_data", tx_data1, 5);
    check_eq("t6_addr", rom_addr1, 0);
    $display("depth1 byte addr %0d data %0d", rom_addr1, tx_data1);
    step();
    check_eq("t6_done", done1, 1);
    check_eq("t6_busy_e3", busy1, 0);
    check_eq("t6_valid_e3", tx_valid1, 0);
    step();
    check_eq("t6_done_pulse", done1, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
